multicycle_sequencer: RTL

Parametrised multi-cycle control sequencer for the RV32I core. It replaces the fixed three-state fetch/execute/memory controller with a handshaked, variable-latency memory interface and a dedicated writeback state. The block sits between the decoder/datapath (action type, immediate, rs1, next-PC) and the single shared instruction/data memory port. It owns the PC, the instruction register and register-file write enable.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/multicycle_sequencer_misalign_check.sv | 35 +++
 rtl/multicycle_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package cpu_pkg;

  typedef enum logic [2:0] {
    ACT_ALU    = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_STORE  = 3'd2,
    ACT_BRANCH = 3'd3,
    ACT_JAL    = 3'd4,
    ACT_JALR   = 3'd5
  } action_t;

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    EXECUTE    = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WRITEBACK  = 3'd5,
    TRAP       = 3'd6
  } seq_state_t;

  localparam logic [2:0] MEM_FUNC3_WORD = 3'b010;

  localparam logic [1:0] TRAP_CAUSE_NONE   = 2'd0;
  localparam logic [1:0] TRAP_CAUSE_LOAD   = 2'd1;
  localparam logic [1:0] TRAP_CAUSE_STORE  = 2'd2;
  localparam logic [1:0] TRAP_CAUSE_TARGET = 2'd3;

endpackage

// File: rtl/multicycle_sequencer_misalign_check.sv
// Combinational alignment checker: data accesses by size, control transfers by target.
module misalign_check
  import cpu_pkg::*;
(
  input  logic [1:0] addr_lsb,
  input  logic [2:0] func3,
  input  action_t    action,
  output logic       misaligned,
  output logic [1:0] cause
);

  always_comb begin
    misaligned = 1'b0;
    cause      = TRAP_CAUSE_NONE;
    case (action)
      ACT_LOAD, ACT_STORE: begin
        case (func3)
          3'b001, 3'b101: misaligned = addr_lsb[0];
          3'b010:         misaligned = |addr_lsb;
          default:        misaligned = 1'b0;
        endcase
        cause = (action == ACT_LOAD) ? TRAP_CAUSE_LOAD : TRAP_CAUSE_STORE;
      end
      ACT_BRANCH, ACT_JAL, ACT_JALR: begin
        misaligned = |addr_lsb;
        cause      = TRAP_CAUSE_TARGET;
      end
      default: begin
        misaligned = 1'b0;
        cause      = TRAP_CAUSE_NONE;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle fetch/execute/memory/writeback sequencer with a handshaked memory port.
// Optional misalignment trapping is enabled by defining MISALIGN_TRAP_EN.
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  action_t         action_type,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] immediate,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] pc_next,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_func3,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [31:0]     mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instruction,
  output logic [31:0]     load_data,
  output logic            reg_wen,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  seq_state_t      r_state;
  seq_state_t      w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_insn;
  logic [31:0]     r_load;
  logic [XLEN-1:0] w_eff_addr;
  logic            w_is_mem;
  logic            w_is_store;
  logic            w_writes_rd;
  logic            w_trap_go;
  logic            w_pc_load;

  assign w_eff_addr  = rs1_data + immediate;
  assign w_is_store  = (action_type == ACT_STORE);
  assign w_is_mem    = (action_type == ACT_LOAD) || w_is_store;
  assign w_writes_rd = (action_type == ACT_ALU) || (action_type == ACT_JAL) ||
                       (action_type == ACT_JALR);

`ifdef MISALIGN_TRAP_EN
  logic [1:0] w_chk_lsb;
  logic       w_chk_misaligned;
  logic [1:0] w_chk_cause;
  logic [1:0] r_trap_cause;

  // Data accesses are checked on the effective address, control transfers on the new PC.
  assign w_chk_lsb = w_is_mem ? w_eff_addr[1:0] : pc_next[1:0];

  misalign_check u_misalign_check (
    .addr_lsb   (w_chk_lsb),
    .func3      (func3),
    .action     (action_type),
    .misaligned (w_chk_misaligned),
    .cause      (w_chk_cause)
  );

  assign w_trap_go = (r_state == EXECUTE) && w_chk_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap_cause <= TRAP_CAUSE_NONE;
    end else if (w_trap_go) begin
      r_trap_cause <= w_chk_cause;
    end
  end

  assign trap       = (r_state == TRAP);
  assign trap_cause = r_trap_cause;
`else
  assign w_trap_go  = 1'b0;
  assign trap       = 1'b0;
  assign trap_cause = TRAP_CAUSE_NONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_REQ:  if (mem_ready) w_state_next = FETCH_WAIT;
      FETCH_WAIT: if (mem_rvalid) w_state_next = EXECUTE;
      EXECUTE: begin
        if (w_trap_go)     w_state_next = TRAP;
        else if (w_is_mem) w_state_next = MEM_REQ;
        else               w_state_next = FETCH_REQ;
      end
      MEM_REQ:    if (mem_ready) w_state_next = w_is_store ? FETCH_REQ : MEM_WAIT;
      MEM_WAIT:   if (mem_rvalid) w_state_next = WRITEBACK;
      WRITEBACK:  w_state_next = FETCH_REQ;
`ifdef MISALIGN_TRAP_EN
      TRAP:       w_state_next = TRAP;
`endif
      default:    w_state_next = FETCH_REQ;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_pc;
    mem_func3 = MEM_FUNC3_WORD;
    reg_wen   = 1'b0;
    case (r_state)
      FETCH_REQ: mem_req = 1'b1;
      EXECUTE:   reg_wen = w_writes_rd && !w_trap_go;
      MEM_REQ: begin
        mem_req   = 1'b1;
        mem_we    = w_is_store;
        mem_addr  = w_eff_addr;
        mem_func3 = func3;
      end
      WRITEBACK: reg_wen = 1'b1;
      default: begin
        mem_req = 1'b0;
        reg_wen = 1'b0;
      end
    endcase
  end

  // PC advances on the final cycle of each instruction, never on a trap.
  assign w_pc_load = ((r_state == EXECUTE) && !w_is_mem && !w_trap_go) ||
                     ((r_state == MEM_REQ) && mem_ready && w_is_store) ||
                     (r_state == WRITEBACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_insn <= NOP_INSN;
      r_load <= '0;
    end else begin
      if (w_pc_load) r_pc <= pc_next;
      if ((r_state == FETCH_WAIT) && mem_rvalid) r_insn <= mem_rdata;
      if ((r_state == MEM_WAIT) && mem_rvalid) r_load <= mem_rdata;
    end
  end

  assign pc          = r_pc;
  assign instruction = r_insn;
  assign load_data   = r_load;

endmodule
